// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side byte packer.
// Holds the packer FSM encoding and the keep-mask builder.
package fifo_pkg;

    typedef enum logic [1:0] {
        FILL,
        DRAIN,
        DONE
    } pk_state_e;

    localparam int PK_MAX_BYTES = 8;

    function automatic logic [PK_MAX_BYTES-1:0] keep_mask(
        input logic [3:0] cnt
    );
        logic [PK_MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < PK_MAX_BYTES; i++) begin
            if (i < int'(cnt)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read side, flush request and packed-word stream of the packer.
// master = packer, slave = surrounding FIFO/sink environment.
interface fifo_rd_packer_if #(
    parameter int BYTES = 4,
    parameter int DW    = 8
);
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DW-1:0]         fifo_dout;
    logic                  flush;
    logic                  m_valid;
    logic                  m_ready;
    logic [BYTES*DW-1:0]   m_data;
    logic [BYTES-1:0]      m_keep;
    logic                  m_last;
    logic                  flush_done;

    modport master (
        input  fifo_empty, fifo_dout, flush, m_ready,
        output fifo_rd_en, m_valid, m_data, m_keep, m_last,
        output flush_done
    );

    modport slave (
        output fifo_empty, fifo_dout, flush, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_keep, m_last,
        input  flush_done
    );
endinterface

// File: rtl/pk_out_reg.sv
// Valid/ready holding register for packed words.
// free_o says a load may happen on this edge without losing a word.
module pk_out_reg #(
    parameter int W = 32,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic [K-1:0] keep_i,
    input  logic         last_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic [K-1:0] keep_o,
    output logic         last_o,
    output logic         free_o
);
    logic         valid_q;
    logic [W-1:0] data_q;
    logic [K-1:0] keep_q;
    logic         last_q;

    assign free_o  = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            keep_q  <= keep_i;
            last_q  <= last_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: rtl/fifo_rd_packer.sv
// Reads bytes from sp_fifo and packs them little-endian into BYTES-wide
// words; flush forces out a partial word marked last.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int BYTES = 4,
    parameter int DW    = 8
) (
    input logic              clk,
    input logic              rst_n,
    fifo_rd_packer_if.master bus
);
    localparam int CW = $clog2(BYTES + 1);
    localparam int W  = BYTES * DW;
    localparam logic [CW-1:0] FULL  = CW'(BYTES);
    localparam logic [CW-1:0] LASTL = CW'(BYTES - 1);
    localparam logic [BYTES-1:0] ALL = '1;

    pk_state_e      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   acc_q, acc_d;
    logic           inflight_q;
    logic           run_q;
    logic           rd_en;
    logic           out_free;
    logic           ld;
    logic [W-1:0]   ld_data;
    logic [BYTES-1:0] ld_keep;
    logic           ld_last;

    // run_q holds off the first read until the cycle after reset release
    assign rd_en = rst_n && run_q && (state_q == FILL) &&
                   !bus.fifo_empty &&
                   (int'(cnt_q) + int'(inflight_q) < BYTES);

    assign bus.fifo_rd_en = rd_en;
    assign bus.flush_done = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FILL;
            cnt_q      <= '0;
            acc_q      <= '0;
            inflight_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            inflight_q <= rd_en;
            run_q      <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ld      = 1'b0;
        ld_data = acc_q;
        ld_keep = '0;
        ld_last = 1'b0;

        if (inflight_q) begin
            acc_d[int'(cnt_q)*DW +: DW] = bus.fifo_dout;
            if (cnt_q == LASTL && out_free) begin
                ld      = 1'b1;
                ld_data = acc_d;
                ld_keep = ALL;
                cnt_d   = '0;
                acc_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            FILL: begin
                if (cnt_q == FULL && out_free) begin
                    ld      = 1'b1;
                    ld_data = acc_q;
                    ld_keep = ALL;
                    ld_last = bus.flush;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
                if (bus.flush) state_d = DRAIN;
            end
            DRAIN: begin
                if (!inflight_q) begin
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else if (out_free) begin
                        ld      = 1'b1;
                        ld_data = acc_q;
                        ld_keep = BYTES'(keep_mask(4'(cnt_q)));
                        ld_last = 1'b1;
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    pk_out_reg #(
        .W (W),
        .K (BYTES)
    ) u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (ld),
        .data_i  (ld_data),
        .keep_i  (ld_keep),
        .last_i  (ld_last),
        .ready_i (bus.m_ready),
        .valid_o (bus.m_valid),
        .data_o  (bus.m_data),
        .keep_o  (bus.m_keep),
        .last_o  (bus.m_last),
        .free_o  (out_free)
    );
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a behavioural sp_fifo model.
// Words on the output stream are logged and compared to hand-made values.
module tb_fifo_rd_packer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic       m_ready = 1'b1;
    logic       fempty = 1'b1;
    logic [7:0] fdout = 8'h00;

    logic [7:0] fq[$];
    int cyc = 0;
    int rd_total = 0;
    int first_rd = -1;
    int underflow = 0;
    int pass = 0;
    int total = 0;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        int          c;
    } w_t;

    typedef struct {
        int          n;
        logic [31:0] bs;
        logic        fl;
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } vec_t;

    w_t wq[$];
    int dq[$];

    always #5 clk = ~clk;

    fifo_rd_packer_if #(.BYTES(4), .DW(8)) bus ();

    assign bus.fifo_empty = fempty;
    assign bus.fifo_dout  = fdout;
    assign bus.flush      = flush;
    assign bus.m_ready    = m_ready;

    fifo_rd_packer #(
        .BYTES (4),
        .DW    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // sp_fifo model: registered empty flag, dout one cycle after rd_en
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            fdout <= 8'h00;
        end else begin
            if (bus.fifo_rd_en) begin
                if (fq.size() == 0) underflow <= underflow + 1;
                else fdout <= fq.pop_front();
            end
            if (wr_en) fq.push_back(wr_data);
        end
        fempty <= (fq.size() == 0);
    end

    always @(negedge clk) begin
        if (bus.m_valid && m_ready)
            wq.push_back('{bus.m_data, bus.m_keep, bus.m_last, cyc});
        if (bus.flush_done) dq.push_back(cyc);
        if (bus.fifo_rd_en) begin
            rd_total++;
            if (first_rd < 0) first_rd = cyc;
        end
    end

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) nxt();
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        nxt();
        wr_en   = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget,
                              input string nm);
        int k;
        k = 0;
        while (wq.size() < n && k < budget) begin
            nxt();
            k++;
        end
        chk(nm, longint'(wq.size() >= n), 1);
    endtask

    task automatic wait_drained();
        int k;
        k = 0;
        while ((fq.size() != 0 || bus.fifo_rd_en) && k < 40) begin
            nxt();
            k++;
        end
        idle(3);
    endtask

    task automatic chk_word(input string nm, input int idx,
                            input logic [31:0] d, input logic [3:0] k,
                            input logic l);
        if (idx >= wq.size()) begin
            chk({nm, "_missing"}, longint'(wq.size()), idx + 1);
        end else begin
            chk({nm, "_data"}, longint'(wq[idx].d), longint'(d));
            chk({nm, "_keep"}, longint'(wq[idx].k), longint'(k));
            chk({nm, "_last"}, longint'(wq[idx].l), longint'(l));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[5];
        int base;
        int bd;
        int rd0;
        int rel;
        int f;
        int bad;
        int k;

        vt[0] = '{4, 32'hEFBEADDE, 1'b0, 32'hEFBEADDE, 4'hF, 1'b0};
        vt[1] = '{4, 32'hFF00FF00, 1'b0, 32'hFF00FF00, 4'hF, 1'b0};
        vt[2] = '{1, 32'h0000005A, 1'b1, 32'h0000005A, 4'h1, 1'b1};
        vt[3] = '{2, 32'h00003CC3, 1'b1, 32'h00003CC3, 4'h3, 1'b1};
        vt[4] = '{3, 32'h00807F01, 1'b1, 32'h00807F01, 4'h7, 1'b1};

        for (int i = 1; i <= 8; i++) fq.push_back(8'(i));

        // reset held with data waiting in the FIFO
        for (int i = 0; i < 2; i++) begin
            nxt();
            chk("rst_rd_en", longint'(bus.fifo_rd_en), 0);
            chk("rst_valid", longint'(bus.m_valid), 0);
            chk("rst_keep", longint'(bus.m_keep), 0);
        end
        rst_n = 1'b1;
        rel = cyc;

        wait_words(2, 60, "stream_cnt");
        chk("first_rd_after_rel", longint'(first_rd > rel), 1);
        chk_word("stream_w0", 0, 32'h04030201, 4'hF, 1'b0);
        chk_word("stream_w1", 1, 32'h08070605, 4'hF, 1'b0);
        if (wq.size() >= 2)
            chk("stream_gap", longint'(wq[1].c - wq[0].c), 5);

        // backpressure: both words accumulate, reads stop
        m_ready = 1'b0;
        base = wq.size();
        rd0 = rd_total;
        for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            nxt();
            if (bus.m_valid && bus.m_data !== 32'h14131211) bad++;
        end
        chk("bp_valid", longint'(bus.m_valid), 1);
        chk("bp_data", longint'(bus.m_data), 32'h14131211);
        chk("bp_stable", longint'(bad), 0);
        chk("bp_rd_en", longint'(bus.fifo_rd_en), 0);
        chk("bp_reads", longint'(rd_total - rd0), 8);
        m_ready = 1'b1;
        wait_words(base + 2, 10, "bp_cnt");
        chk_word("bp_w0", base, 32'h14131211, 4'hF, 1'b0);
        chk_word("bp_w1", base + 1, 32'h18171615, 4'hF, 1'b0);
        if (wq.size() >= base + 2)
            chk("bp_gap", longint'(wq[base+1].c - wq[base].c), 1);

        // table: full words and flushed partial words
        for (int v = 0; v < 5; v++) begin
            base = wq.size();
            bd = dq.size();
            for (int i = 0; i < vt[v].n; i++)
                push(vt[v].bs[i*8 +: 8]);
            wait_drained();
            if (vt[v].fl) begin
                flush = 1'b1;
                nxt();
                flush = 1'b0;
            end
            wait_words(base + 1, 30, $sformatf("vec%0d_cnt", v));
            chk_word($sformatf("vec%0d", v), base,
                     vt[v].d, vt[v].k, vt[v].l);
            if (vt[v].fl) begin
                idle(3);
                chk($sformatf("vec%0d_done", v),
                    longint'(dq.size()), longint'(bd + 1));
            end
        end

        // flush while the last byte read is in flight
        idle(3);
        base = wq.size();
        bd = dq.size();
        rd0 = rd_total;
        push(8'hA0);
        push(8'hA1);
        push(8'hA2);
        k = 0;
        while (rd_total < rd0 + 3 && k < 30) begin
            nxt();
            k++;
        end
        f = cyc;
        flush = 1'b1;
        nxt();
        flush = 1'b0;
        wait_words(base + 1, 20, "pf_cnt");
        chk_word("pf", base, 32'h00A2A1A0, 4'h7, 1'b1);
        if (wq.size() > base)
            chk("pf_word_cyc", longint'(wq[base].c), longint'(f + 2));
        idle(3);
        chk("pf_done_cnt", longint'(dq.size()), longint'(bd + 1));
        chk("pf_done_cyc",
            longint'((dq.size() > bd) ? dq[bd] : -1), longint'(f + 2));

        // flush with nothing accumulated
        idle(3);
        base = wq.size();
        bd = dq.size();
        f = cyc;
        flush = 1'b1;
        nxt();
        flush = 1'b0;
        idle(6);
        chk("ef_no_word", longint'(wq.size()), longint'(base));
        chk("ef_done_cnt", longint'(dq.size()), longint'(bd + 1));
        chk("ef_done_cyc",
            longint'((dq.size() > bd) ? dq[bd] : -1), longint'(f + 2));

        // flush while a full word is held behind a stalled output
        m_ready = 1'b0;
        base = wq.size();
        bd = dq.size();
        for (int i = 0; i < 8; i++) push(8'h21 + 8'(i));
        idle(20);
        flush = 1'b1;
        nxt();
        flush = 1'b0;
        idle(2);
        m_ready = 1'b1;
        wait_words(base + 2, 10, "hf_cnt");
        chk_word("hf_w0", base, 32'h24232221, 4'hF, 1'b0);
        chk_word("hf_w1", base + 1, 32'h28272625, 4'hF, 1'b1);
        idle(3);
        chk("hf_done_cnt", longint'(dq.size()), longint'(bd + 1));

        // reset with two bytes captured
        idle(3);
        push(8'h77);
        push(8'h66);
        wait_drained();
        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
        base = wq.size();
        for (int i = 0; i < 4; i++) push(8'h55 + 8'(i));
        wait_words(base + 1, 40, "rm_cnt");
        chk_word("rm", base, 32'h58575655, 4'hF, 1'b0);
        idle(10);
        chk("rm_one_word", longint'(wq.size()), longint'(base + 1));

        chk("no_underflow", longint'(underflow), 0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
